// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented ripple-carry adder/subtractor, one SEG_W-bit segment per stage, valid/ready handshake
// Ports: clk_i clock; rst_i async active-low reset;
//        in_valid_i/in_ready_o, a_i, b_i, sub_i, cin_i form the operand beat;
//        out_valid_o/out_ready_i, sum_o, cout_o, ovf_o, zero_o form the result beat.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int STAGES = WIDTH / SEG_W;
  logic [STAGES-1:0] v;
  logic [STAGES:0] rdy;
  logic ovf_q, zero_q;
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x, input logic [SEG_W-1:0] y, input logic ci);
    logic [SEG_W:0] c;
    logic [SEG_W-1:0] s;
    c = '0;
    s = '0;
    c[0] = ci;
    for (int i = 0; i < SEG_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[SEG_W], s};
  endfunction
  always_comb begin
    rdy[STAGES] = out_ready_i;
    for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
  end
  assign in_ready_o = rdy[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // R: operand bits still unsummed on entry; L: result bits known after this stage
    localparam int R = WIDTH - k * SEG_W;
    localparam int L = (k + 1) * SEG_W;
    logic iv, ci, vq, cq;
    logic [R-1:0] ai, bi;
    logic [L-1:0] sn, sq;
    logic [SEG_W:0] r;
    if (k == 0) begin : g_in
      assign iv = in_valid_i;
      assign ai = a_i;
      assign bi = sub_i ? ~b_i : b_i;
      assign ci = cin_i ^ sub_i;
      assign sn = r[SEG_W-1:0];
    end else begin : g_mid
      assign iv = g_st[k-1].vq;
      assign ai = g_st[k-1].g_op.aq;
      assign bi = g_st[k-1].g_op.bq;
      assign ci = g_st[k-1].cq;
      assign sn = {r[SEG_W-1:0], g_st[k-1].sq};
    end
    assign r = seg_add(ai[SEG_W-1:0], bi[SEG_W-1:0], ci);
    assign v[k] = vq;
    // operands are shifted down so the next segment always sits at bit 0
    if (k < STAGES - 1) begin : g_op
      logic [R-SEG_W-1:0] aq, bq;
      always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
          aq <= '0;
          bq <= '0;
        end else if (rdy[k] && iv) begin
          aq <= ai[R-1:SEG_W];
          bq <= bi[R-1:SEG_W];
        end
    end
    always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else begin
        if (rdy[k]) vq <= iv;
        if (rdy[k] && iv) begin
          cq <= r[SEG_W];
          sq <= sn;
        end
      end
  end
  // carry into the MSB is recovered as a^b^sum at that bit
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (rdy[STAGES-1] && g_st[STAGES-1].iv) begin
      ovf_q <= g_st[STAGES-1].ai[SEG_W-1] ^ g_st[STAGES-1].bi[SEG_W-1] ^ g_st[STAGES-1].r[SEG_W-1] ^ g_st[STAGES-1].r[SEG_W];
      zero_q <= ~|g_st[STAGES-1].sn;
    end
  assign out_valid_o = v[STAGES-1];
  assign sum_o = g_st[STAGES-1].sq;
  assign cout_o = g_st[STAGES-1].cq;
  assign ovf_o = ovf_q;
  assign zero_o = zero_q;
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, segmented ripple-carry adder/subtractor; it generalises the team's 1-bit full-adder cell to WIDTH bits.
- The operand is split into segments of SEG_W bits. Each segment is computed in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on input and output, with per-stage bubble collapsing.
- Sits between operand fetch and writeback in the lab datapath. It replaces the single-cycle ALU add path when timing requires it.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SEG_W, 8, bits summed per stage. Must divide WIDTH. Derived localparam STAGES = WIDTH/SEG_W.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept a beat this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- sub_i  input  1  0 = A+B+cin, 1 = A-B-cin (borrow-in).
- cin_i  input  1  carry-in (add) / borrow-in (sub).
- out_valid_o  output  1  result beat valid.
- out_ready_i  input  1  consumer accepts result this cycle.
- sum_o  output  WIDTH  result.
- cout_o  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf_o  output  1  two's-complement signed overflow.
- zero_o  output  1  sum_o == 0.

Behaviour:
- Operation: B' = sub_i ? ~b_i : b_i; c0 = cin_i XOR sub_i; result = A + B' + c0, taken modulo 2^WIDTH.
- Transfers:
  - Input transfer when in_valid_i && in_ready_o.
  - Output transfer when out_valid_o && out_ready_i.
- Stage k (0..STAGES-1) holds:
  - valid_k;
  - registered carry;
  - low k*SEG_W result bits already computed;
  - remaining operand segments of A and B' still to be summed.
- Stage 0 captures the input beat and computes segment 0 in the same capture. Stage k>0 computes segment k from its predecessor's carry. Each segment add is a SEG_W-bit ripple of full-adder equations.
- Latency: a beat accepted at edge t presents out_valid_o=1 after edge t+STAGES-1. With STAGES=1 the result is valid the cycle after acceptance.
- Throughput: one beat per cycle when out_ready_i stays high.
- Ready chain:
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready_i.
  - in_ready_o = ready_0, combinational from out_ready_i through the chain.
  - A stage advances only if the next stage is ready. Bubbles collapse, so a full pipe holds STAGES beats.
- Stall: when out_valid_o && !out_ready_i, the last stage holds sum_o/cout_o/ovf_o/zero_o stable. Earlier stages fill any bubbles; in_ready_o goes low once all stages are valid.
- Accept and emit in the same cycle on a full pipe with out_ready_i=1: legal, no beat lost or duplicated.
- Flags, computed in the final stage from final-stage registers:
  - cout_o = carry out of bit WIDTH-1.
  - ovf_o = carry into bit WIDTH-1 XOR cout_o.
  - zero_o = ~|sum_o.
- Outputs are valid only when out_valid_o=1. Contents when invalid are don't-care, except in reset.
- Reset (rst_i=0, any time, including mid-stream):
  - all valid_k=0, out_valid_o=0;
  - sum_o=0, cout_o=0, ovf_o=0, zero_o=0 (forced, not derived);
  - in-flight beats are discarded.
  - in_ready_o=1 from the first edge after release, subject to the ready chain.
- in_valid_i, a_i, b_i, sub_i and cin_i are sampled only on an accepting edge. Changes while in_ready_o=0 have no effect.

Test Plan (WIDTH=32, SEG_W=8, STAGES=4):
- Add across all segment boundaries: A=0x0000_00FF... → see below. Concretely, A=0xFFFF_FFFF, B=0x0000_0001, sub=0, cin=0 → after 4 edges, sum=0x0000_0000, cout=1, ovf=0, zero=1.
- Signed overflow: A=0x7FFF_FFFF, B=1, add → sum=0x8000_0000, cout=0, ovf=1.
- Subtract with borrow:
  - A=5, B=7, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0.
  - Same operands with cin=1 → sum=0xFFFF_FFFD.
- Back-to-back streaming: 10 random beats on consecutive cycles with out_ready_i=1 → 10 results in order, first at cycle 4, one per cycle, each matching a reference model.
- Backpressure: hold out_ready_i=0 while sending beats → in_ready_o falls after exactly 4 accepted beats and sum_o stays stable. Release → all 4 drain in order, none lost or duplicated.
- Reset mid-stream: assert rst_i=0 with 3 beats in flight → out_valid_o=0 and sum_o=0 immediately (asynchronous). After release, no stale beats emerge and a new beat 1+2 yields 3 after 4 cycles.
